// File: rtl/imem_loader.sv
// Streams a little-endian byte image (16-bit word-count header, then payload) into instruction
// memory and releases the core reset on success. Define IMEM_LOADER_CSUM_EN for a trailing XOR check.
module imem_loader #(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_rst_n
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StHdr0 = 3'd1;
  localparam logic [2:0] StHdr1 = 3'd2;
  localparam logic [2:0] StLoad = 3'd3;
  localparam logic [2:0] StDone = 3'd4;
  localparam logic [2:0] StErr  = 3'd5;
`ifdef IMEM_LOADER_CSUM_EN
  localparam logic [2:0] StCsum = 3'd6;
`endif

  logic [2:0]      state_q, state_d;
  logic [1:0]      byte_cnt_q;
  logic [CntW-1:0] word_cnt_q;
  logic [15:0]     num_words_q;
  logic [23:0]     asm_q;
  logic            wr_en_q;
  logic [31:0]     wr_addr_q, wr_data_q;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]      csum_q;
`endif

  logic        xfer;
  logic        start_ok;
  logic [15:0] hdr_n;
  logic        hdr_bad;
  logic        last_word;

  assign xfer      = byte_valid & byte_ready;
  assign start_ok  = load_start & ((state_q == StIdle) | (state_q == StDone) | (state_q == StErr));
  assign hdr_n     = {byte_data, num_words_q[7:0]};
  assign hdr_bad   = (hdr_n == 16'd0) || (32'(hdr_n) > DEPTH);
  assign last_word = (32'(word_cnt_q) == (32'(num_words_q) - 32'd1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone, StErr: if (load_start) state_d = StHdr0;
      StHdr0: if (xfer) state_d = StHdr1;
      StHdr1: if (xfer) state_d = hdr_bad ? StErr : StLoad;
      StLoad: begin
        if (xfer && (byte_cnt_q == 2'd3) && last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
          state_d = StCsum;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      StCsum: if (xfer) state_d = (byte_data == csum_q) ? StDone : StErr;
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      byte_cnt_q  <= '0;
      word_cnt_q  <= '0;
      num_words_q <= '0;
      asm_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q <= state_d;
      wr_en_q <= 1'b0;
      if (start_ok) begin
        byte_cnt_q <= '0;
        word_cnt_q <= '0;
`ifdef IMEM_LOADER_CSUM_EN
        csum_q     <= '0;
`endif
      end
      if ((state_q == StHdr0) && xfer) num_words_q[7:0]  <= byte_data;
      if ((state_q == StHdr1) && xfer) num_words_q[15:8] <= byte_data;
      if ((state_q == StLoad) && xfer) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
        csum_q     <= csum_q ^ byte_data;
`endif
        if (byte_cnt_q == 2'd3) begin
          // Word complete: strobe next cycle; the address tracks the word index, not a running sum.
          wr_en_q    <= 1'b1;
          wr_data_q  <= {byte_data, asm_q};
          wr_addr_q  <= BASE_ADDR + (32'(word_cnt_q) << 2);
          word_cnt_q <= word_cnt_q + 1'b1;
        end else begin
          asm_q[{byte_cnt_q, 3'b000} +: 8] <= byte_data;
        end
      end
    end
  end

  always_comb begin
    byte_ready = (state_q == StHdr0) || (state_q == StHdr1) || (state_q == StLoad);
`ifdef IMEM_LOADER_CSUM_EN
    byte_ready = byte_ready || (state_q == StCsum);
`endif
    busy      = byte_ready;
    done      = (state_q == StDone);
    error     = (state_q == StErr);
    cpu_rst_n = (state_q == StDone);
    wr_en     = wr_en_q;
    wr_addr   = wr_addr_q;
    wr_data   = wr_data_q;
  end

endmodule
